hazard_scheduler: RTL



---
 rtl/hazard_scheduler_pkg.sv | 24 ++
 rtl/hazard_scheduler_load_use_detect.sv | 31 +++
 rtl/hazard_scheduler.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/hazard_scheduler_pkg.sv
// -----------------------------------------------------------------------------
// hazard_scheduler_pkg
// Shared pipeline definitions for the hazard scheduler:
//   - hs_state_e     : scheduler FSM state encoding (RUN, MD_WAIT)
//   - MD_TIMEOUT_DEF : default mul/div wait limit in cycles
//   - src_match()    : one operand of the load-use comparison
// -----------------------------------------------------------------------------
package hazard_scheduler_pkg;

  typedef enum logic [0:0] {
    ST_RUN     = 1'b0,
    ST_MD_WAIT = 1'b1
  } hs_state_e;

  localparam int MD_TIMEOUT_DEF = 40;

  // True when the ID instruction actually reads rs and rs equals the EX destination
  function automatic logic src_match(input logic use_src,
                                     input logic [4:0] rs,
                                     input logic [4:0] rd);
    return use_src && (rs == rd);
  endfunction

endpackage

// File: rtl/hazard_scheduler_load_use_detect.sv
// -----------------------------------------------------------------------------
// load_use_detect
// Combinational load-use hazard detector: flags an ID instruction that reads
// the destination of a load currently in EX (x0 never creates a hazard).
// Ports:
//   ID_rs1, ID_rs2         : ID source register numbers
//   ID_use_rs1, ID_use_rs2 : ID instruction reads that source
//   EX_memread             : EX instruction is a load
//   EX_rd                  : EX destination register
//   hit                    : load-use hazard present
// -----------------------------------------------------------------------------
module load_use_detect
  import hazard_scheduler_pkg::*;
(
  input  logic [4:0] ID_rs1,
  input  logic [4:0] ID_rs2,
  input  logic       ID_use_rs1,
  input  logic       ID_use_rs2,
  input  logic       EX_memread,
  input  logic [4:0] EX_rd,
  output logic       hit
);

  // Load in EX with a real destination that either used source matches
  always_comb begin
    hit = EX_memread && (EX_rd != 5'd0) &&
          (src_match(ID_use_rs1, ID_rs1, EX_rd) ||
           src_match(ID_use_rs2, ID_rs2, EX_rd));
  end

endmodule

// File: rtl/hazard_scheduler.sv
// -----------------------------------------------------------------------------
// hazard_scheduler
// Pipeline hazard control: multi-cycle mul/div launch and wait (with timeout),
// branch flush, load-use stall, plus a saturating stall-cycle counter.
// Parameters:
//   MD_TIMEOUT : max MD_WAIT cycles before the wait is aborted
//   CNT_W      : width of stall_cycles
// Ports:
//   clk, reset              : clock, asynchronous active-high reset
//   ID_rs1/2, ID_use_rs1/2  : ID-stage source operands
//   EX_memread, EX_rd       : EX-stage load information
//   EX_branch_taken         : EX redirects the PC
//   EX_md_op, md_done       : mul/div op in EX, result-valid pulse
//   pc_write, IFID_write    : front-end write enables
//   IFID_flush, IDEX_flush  : bubble insertion
//   EX_hold                 : freeze ID/EX and EX/MEM
//   md_start                : mul/div launch pulse
//   md_error                : sticky mul/div timeout flag
//   stall_cycles            : saturating count of cycles with pc_write low
// -----------------------------------------------------------------------------
module hazard_scheduler
  import hazard_scheduler_pkg::*;
#(
  parameter int MD_TIMEOUT = MD_TIMEOUT_DEF,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       ID_rs1,
  input  logic [4:0]       ID_rs2,
  input  logic             ID_use_rs1,
  input  logic             ID_use_rs2,
  input  logic             EX_memread,
  input  logic [4:0]       EX_rd,
  input  logic             EX_branch_taken,
  input  logic             EX_md_op,
  input  logic             md_done,
  output logic             pc_write,
  output logic             IFID_write,
  output logic             IFID_flush,
  output logic             IDEX_flush,
  output logic             EX_hold,
  output logic             md_start,
  output logic             md_error,
  output logic [CNT_W-1:0] stall_cycles
);

  // Counter can reach MD_TIMEOUT on the exit edge, so size for that value
  localparam int              WAIT_W    = $clog2(MD_TIMEOUT + 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MD_TIMEOUT - 1);

  hs_state_e         state_r;
  hs_state_e         state_nxt_s;
  logic [WAIT_W-1:0] wait_cnt_r;
  logic              md_error_r;
  logic [CNT_W-1:0]  stall_cnt_r;
  logic              load_use_s;
  logic              timeout_s;
  logic              release_s;

  load_use_detect u_load_use_detect (
    .ID_rs1     (ID_rs1),
    .ID_rs2     (ID_rs2),
    .ID_use_rs1 (ID_use_rs1),
    .ID_use_rs2 (ID_use_rs2),
    .EX_memread (EX_memread),
    .EX_rd      (EX_rd),
    .hit        (load_use_s)
  );

  // Wait-exit conditions; md_done wins over a simultaneous timeout
  always_comb begin
    timeout_s = (state_r == ST_MD_WAIT) && (wait_cnt_r == WAIT_LAST);
    release_s = (state_r == ST_MD_WAIT) && (md_done || timeout_s);
  end

  // FSM state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= ST_RUN;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // FSM next-state logic
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_RUN: begin
        if (EX_md_op) begin
          state_nxt_s = ST_MD_WAIT;
        end else begin
          state_nxt_s = ST_RUN;
        end
      end
      ST_MD_WAIT: begin
        if (release_s) begin
          state_nxt_s = ST_RUN;
        end else begin
          state_nxt_s = ST_MD_WAIT;
        end
      end
      default: state_nxt_s = ST_RUN;
    endcase
  end

  // FSM outputs; reset forces the idle pattern so a pending md_op cannot launch
  always_comb begin
    pc_write   = 1'b1;
    IFID_write = 1'b1;
    IFID_flush = 1'b0;
    IDEX_flush = 1'b0;
    EX_hold    = 1'b0;
    md_start   = 1'b0;
    if (reset) begin
      pc_write = 1'b1;
    end else begin
      case (state_r)
        ST_MD_WAIT: begin
          // Release cycle keeps the normal-flow pattern
          if (release_s) begin
            EX_hold = 1'b0;
          end else begin
            pc_write   = 1'b0;
            IFID_write = 1'b0;
            EX_hold    = 1'b1;
          end
        end
        ST_RUN: begin
          if (EX_md_op) begin
            md_start   = 1'b1;
            pc_write   = 1'b0;
            IFID_write = 1'b0;
            EX_hold    = 1'b1;
          end else if (EX_branch_taken) begin
            IFID_flush = 1'b1;
            IDEX_flush = 1'b1;
          end else if (load_use_s) begin
            pc_write   = 1'b0;
            IFID_write = 1'b0;
            IDEX_flush = 1'b1;
          end else begin
            pc_write = 1'b1;
          end
        end
        default: begin
          pc_write = 1'b1;
        end
      endcase
    end
  end

  // Wait counter: zero while in RUN so each wait starts from 0
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wait_cnt_r <= '0;
    end else if (state_r == ST_MD_WAIT) begin
      wait_cnt_r <= wait_cnt_r + WAIT_W'(1);
    end else begin
      wait_cnt_r <= '0;
    end
  end

  // Sticky timeout flag, only set when md_done did not arrive that cycle
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      md_error_r <= 1'b0;
    end else if (timeout_s && !md_done) begin
      md_error_r <= 1'b1;
    end else begin
      md_error_r <= md_error_r;
    end
  end

  // Saturating stall-cycle counter
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cnt_r <= '0;
    end else if (!pc_write && (stall_cnt_r != {CNT_W{1'b1}})) begin
      stall_cnt_r <= stall_cnt_r + CNT_W'(1);
    end else begin
      stall_cnt_r <= stall_cnt_r;
    end
  end

  assign md_error     = md_error_r;
  assign stall_cycles = stall_cnt_r;

endmodule
